// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - in-order instruction fetch queue with branch flush
//
// Purpose:
//   Takes one PC per cycle from the program counter, issues it to instruction
//   memory over a req/gnt bus, collects the in-order responses into a
//   DEPTH-entry {pc, instr} queue and presents the head entry to decode with
//   valid/ready. A flush empties the queue and arranges for every response
//   still in flight to be discarded when it arrives.
//
// Optional feature (macro FETCH_ALIGN_CHECK_EN):
//   A PC with pc_i[1:0] != 0 is not sent to memory. Once the pipe is idle it is
//   accepted and enqueued as an already-filled NOP (32'h0000_0013) with err = 1,
//   reported on dec_err_o. Without the macro dec_err_o is tied 0.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   pc_i, pc_valid_i    fetch address and its valid
//   pc_ready_o          pc_i consumed this cycle
//   imem_req_o          memory request, address on imem_addr_o (= pc_i)
//   imem_gnt_i          request accepted this cycle
//   imem_rvalid_i       in-order response valid, data on imem_rdata_i
//   flush_i             redirect: drop queue and in-flight fetches
//   dec_valid_o         head entry valid to decode, accepted by dec_ready_i
//   dec_pc_o            head entry PC
//   dec_instr_o         head entry instruction
//   dec_err_o           head entry misaligned flag

module instr_fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  output logic              pc_ready_o,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  input  logic              flush_i,
  output logic              dec_valid_o,
  input  logic              dec_ready_i,
  output logic [ADDR_W-1:0] dec_pc_o,
  output logic [DATA_W-1:0] dec_instr_o,
  output logic              dec_err_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW:0] DEPTH_W = (PW + 1)'(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]     alloc;
  logic [PW-1:0]     fill;
  logic [PW-1:0]     rd;
  logic [PW-1:0]     out_cnt;
  logic [PW-1:0]     drop_cnt;
  logic [DEPTH-1:0]  filled;
  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];

  logic [IW-1:0] alloc_idx;
  logic [IW-1:0] fill_idx;
  logic [IW-1:0] rd_idx;
  logic [PW-1:0] occ;
  logic [PW:0]   committed;
  logic          credit;
  logic          grant;
  logic          rsp_keep;
  logic          head_valid;
  logic          pop;
  logic          accept_mis;

  assign alloc_idx = alloc[IW-1:0];
  assign fill_idx  = fill[IW-1:0];
  assign rd_idx    = rd[IW-1:0];

  // Slots still owed to pending drops count against space, so a response can
  // never arrive without a free slot waiting for it.
  assign occ       = alloc - rd;
  assign committed = {1'b0, occ} + {1'b0, drop_cnt};
  assign credit    = committed < DEPTH_W;

`ifdef FETCH_ALIGN_CHECK_EN
  logic [DEPTH-1:0] err;
  logic             misaligned;

  assign misaligned = pc_i[1:0] != 2'b00;
  // Only taken with nothing in flight, so fill == alloc and the entry can be
  // allocated and filled on the same edge without disturbing response order.
  assign accept_mis = reset_n & pc_valid_i & misaligned & credit &
                      (out_cnt == '0) & (drop_cnt == '0) & !flush_i;
  assign imem_req_o = reset_n & pc_valid_i & credit & !flush_i & !misaligned;
`else
  assign accept_mis = 1'b0;
  assign imem_req_o = reset_n & pc_valid_i & credit & !flush_i;
`endif

  assign imem_addr_o = pc_i;
  assign grant       = imem_req_o & imem_gnt_i;
  assign pc_ready_o  = grant | accept_mis;
  assign rsp_keep    = imem_rvalid_i & (drop_cnt == '0);

  assign head_valid  = (rd != alloc) & filled[rd_idx];
  assign dec_valid_o = head_valid & !flush_i;
  assign pop         = dec_valid_o & dec_ready_i;

  assign dec_pc_o    = head_valid ? pc_mem[rd_idx] : '0;
  assign dec_instr_o = head_valid ? instr_mem[rd_idx] : '0;
`ifdef FETCH_ALIGN_CHECK_EN
  assign dec_err_o   = head_valid & err[rd_idx];
`else
  assign dec_err_o   = 1'b0;
`endif

  // Control state: pointers, counters and per-entry filled flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alloc    <= '0;
      fill     <= '0;
      rd       <= '0;
      out_cnt  <= '0;
      drop_cnt <= '0;
      filled   <= '0;
    end else if (flush_i) begin
      // Everything granted but unanswered becomes a drop; a response arriving
      // this very cycle retires one of them (live or already dropped).
      rd       <= alloc;
      fill     <= alloc;
      filled   <= '0;
      out_cnt  <= '0;
      drop_cnt <= drop_cnt + out_cnt - PW'(imem_rvalid_i);
    end else begin
      if (grant) begin
        filled[alloc_idx] <= 1'b0;
        alloc             <= alloc + PW'(1);
      end
      if (accept_mis) begin
        filled[alloc_idx] <= 1'b1;
        alloc             <= alloc + PW'(1);
        fill              <= fill + PW'(1);
      end
      if (imem_rvalid_i) begin
        if (drop_cnt != '0) begin
          drop_cnt <= drop_cnt - PW'(1);
        end else begin
          filled[fill_idx] <= 1'b1;
          fill             <= fill + PW'(1);
        end
      end
      if (pop) begin
        filled[rd_idx] <= 1'b0;
        rd             <= rd + PW'(1);
      end
      out_cnt <= out_cnt + PW'(grant) - PW'(rsp_keep);
    end
  end

  // Entry payload needs no reset: it is only visible while its filled bit is set.
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      if (grant) begin
        pc_mem[alloc_idx] <= pc_i;
`ifdef FETCH_ALIGN_CHECK_EN
        err[alloc_idx]    <= 1'b0;
`endif
      end
`ifdef FETCH_ALIGN_CHECK_EN
      if (accept_mis) begin
        pc_mem[alloc_idx]    <= pc_i;
        instr_mem[alloc_idx] <= DATA_W'(32'h0000_0013);
        err[alloc_idx]       <= 1'b1;
      end
`endif
      if (rsp_keep) begin
        instr_mem[fill_idx] <= imem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - scoreboard bench for instr_fetch_queue
module tb_instr_fetch_queue;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] pc_i = '0;
  logic          pc_valid_i = 1'b0;
  logic          pc_ready_o;
  logic          imem_req_o;
  logic [AW-1:0] imem_addr_o;
  logic          imem_gnt_i = 1'b0;
  logic          imem_rvalid_i = 1'b0;
  logic [DW-1:0] imem_rdata_i = '0;
  logic          flush_i = 1'b0;
  logic          dec_valid_o;
  logic          dec_ready_i = 1'b0;
  logic [AW-1:0] dec_pc_o;
  logic [DW-1:0] dec_instr_o;
  logic          dec_err_o;

  instr_fetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .pc_i(pc_i), .pc_valid_i(pc_valid_i),
    .pc_ready_o(pc_ready_o), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .flush_i(flush_i), .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .dec_pc_o(dec_pc_o), .dec_instr_o(dec_instr_o), .dec_err_o(dec_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];   // accepted since last flush, not yet popped by decode
  logic [AW-1:0] pend_q[$];  // every granted request awaiting its memory response
  int            stale_cnt;  // leading pend_q entries issued before a flush
  int            n_checks = 0;
  int            n_fail = 0;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check1(input string name, input logic act, input logic want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, want, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: queue occupancy, outstanding and stale fetches decide
  // what the handshake outputs must be this cycle; then the cycle is retired.
  always @(negedge clk) begin : model
    int   live;
    bit   cr, mis, ereq, emis, erdy;
    exp_t e;
    if (!reset_n) begin
      exp_q.delete();
      pend_q.delete();
      stale_cnt = 0;
    end else begin
      live = pend_q.size() - stale_cnt;
      cr   = (exp_q.size() + stale_cnt) < DEPTH;
`ifdef FETCH_ALIGN_CHECK_EN
      mis  = pc_i[1:0] != 2'b00;
`else
      mis  = 1'b0;
`endif
      ereq = pc_valid_i && cr && !flush_i && !mis;
      emis = pc_valid_i && mis && cr && live == 0 && stale_cnt == 0 && !flush_i;
      erdy = (ereq && imem_gnt_i) || emis;
      check1("imem_req", imem_req_o, ereq);
      if (ereq) check32("imem_addr", imem_addr_o, pc_i);
      check1("pc_ready", pc_ready_o, erdy);
      // The newest 'live' accepted entries still lack their instruction.
      check1("dec_valid", dec_valid_o, (exp_q.size() > live) && !flush_i);
      if (imem_rvalid_i) begin
        void'(pend_q.pop_front());
        if (stale_cnt > 0) stale_cnt--;
      end
      if (flush_i) begin
        exp_q.delete();
        stale_cnt = pend_q.size();
      end else if (erdy) begin
        e.pc = pc_i;
        if (mis) begin
          e.instr = 32'h0000_0013;
          e.err   = 1'b1;
        end else begin
          e.instr = mem_f(pc_i);
          e.err   = 1'b0;
          pend_q.push_back(pc_i);
        end
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: every entry handed to decode must be the oldest expected one.
  always @(negedge clk) begin : monitor
    exp_t e;
    #1;
    if (reset_n && dec_valid_o && dec_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dec_unexpected: got pc %h with nothing expected at %0t", dec_pc_o, $time);
      end else begin
        e = exp_q.pop_front();
        check32("dec_pc", dec_pc_o, e.pc);
        check32("dec_instr", dec_instr_o, e.instr);
        check1("dec_err", dec_err_o, e.err);
      end
    end
  end

  // One cycle of stimulus; memory answers the oldest pending request with
  // probability rv_pct percent.
  task automatic cyc(input bit v, input logic [31:0] p, input bit g, input int rv_pct,
                     input bit fl, input bit rdy);
    pc_valid_i  = v;
    pc_i        = p;
    imem_gnt_i  = g;
    flush_i     = fl;
    dec_ready_i = rdy;
    if (pend_q.size() > 0 && int'($urandom_range(99)) < rv_pct) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_f(pend_q[0]);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'hDEAD_BEEF;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 32'h0, 1'b0, 100, 1'b0, 1'b1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] r;
    pc_valid_i = 1'b1;
    imem_gnt_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_req", imem_req_o, 1'b0);
    check1("rst_pc_ready", pc_ready_o, 1'b0);
    check1("rst_dec_valid", dec_valid_o, 1'b0);
    check32("rst_dec_pc", dec_pc_o, 32'h0);
    check32("rst_dec_instr", dec_instr_o, 32'h0);
    check1("rst_dec_err", dec_err_o, 1'b0);
    reset_n = 1'b1;

    // Single fetch of PC 0 answered one cycle later.
    cyc(1'b1, 32'h0, 1'b1, 100, 1'b0, 1'b1);
    idle(4);

    // Back-to-back stream with k = 1.
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'(i * 4), 1'b1, 100, 1'b0, 1'b1);
    idle(4);

    // Fill the queue with decode stalled, then pop once.
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'(32'h200 + i * 4), 1'b1, 100, 1'b0, 1'b0);
    cyc(1'b1, 32'h220, 1'b1, 100, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'(32'h240 + i * 4), 1'b1, 100, 1'b0, 1'b0);
    idle(8);

    // Three fetches in flight, flush, then a redirected fetch at 0x100.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'(32'h300 + i * 4), 1'b1, 0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 0, 1'b1, 1'b1);
    cyc(1'b1, 32'h100, 1'b1, 100, 1'b0, 1'b1);
    idle(8);

    // Grant, response and flush all in one cycle.
    for (int i = 0; i < 2; i++) cyc(1'b1, 32'(32'h400 + i * 4), 1'b1, 0, 1'b0, 1'b0);
    cyc(1'b1, 32'h500, 1'b1, 100, 1'b1, 1'b1);
    idle(6);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned PC with the pipe idle.
    cyc(1'b1, 32'h6, 1'b1, 100, 1'b0, 1'b1);
    idle(3);
`endif

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      r = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
      if ($urandom_range(99) >= 20) r[1:0] = 2'b00;
`else
      r[1:0] = 2'b00;
`endif
      cyc($urandom_range(99) < 70, r, $urandom_range(99) < 70, 60,
          $urandom_range(99) < 3, $urandom_range(99) < 70);
    end

    // Drain, bounded.
    for (int i = 0; i < 60 && (exp_q.size() > 0 || pend_q.size() > 0); i++) idle(1);
    check1("drain_empty", exp_q.size() == 0 && pend_q.size() == 0, 1'b1);

    // Reset in the middle of operation with entries waiting.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'(32'h600 + i * 4), 1'b1, 100, 1'b0, 1'b0);
    reset_n       = 1'b0;
    pc_valid_i    = 1'b1;
    imem_gnt_i    = 1'b1;
    imem_rvalid_i = 1'b0;
    #1;
    check1("mid_rst_dec_valid", dec_valid_o, 1'b0);
    check32("mid_rst_dec_pc", dec_pc_o, 32'h0);
    check32("mid_rst_dec_instr", dec_instr_o, 32'h0);
    check1("mid_rst_req", imem_req_o, 1'b0);
    check1("mid_rst_pc_ready", pc_ready_o, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(32'h700 + i * 4), 1'b1, 100, 1'b0, 1'b1);
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
